// File: rtl/vdp_pkg.sv
// Shared geometry constants and slot storage type for the VDP sprite line buffer.
package vdp_pkg;

    localparam int NUM_SLOTS    = 8;
    localparam int H_TOTAL      = 800;
    localparam int ACTIVE_START = 64;
    localparam int ACTIVE_END   = 576;
    localparam int ROW_FIRST    = 48;
    localparam int ROW_LAST     = 431;

    typedef struct packed {
        logic            valid;
        logic [7:0]      hpos;
        logic [3:0][7:0] planes;
    } spr_slot_t;

endpackage

// File: rtl/vdp_sprite_slot.sv
// One sprite slot: front/back bank storage plus the pixel lookup on the front bank.
module vdp_sprite_slot
    import vdp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_L,
    input  logic            bank_sel_i,
    input  logic            swap_i,
    input  logic            clr_all_i,
    input  logic            wr_i,
    input  logic [7:0]      wr_hpos_i,
    input  logic [3:0][7:0] wr_planes_i,
    input  logic [7:0]      x_i,
    input  logic            active_i,
    output logic            opq_o,
    output logic [3:0]      pix_o
);

    spr_slot_t bank_q [2];
    spr_slot_t bank_d [2];
    spr_slot_t front;
    logic      back_idx;
    logic [8:0] dx;
    logic [2:0] bit_idx;
    logic       in_range;

    assign back_idx = ~bank_sel_i;

    // The bank leaving front duty becomes the new back and must start empty.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        if (wr_i) begin
            bank_d[back_idx].valid  = 1'b1;
            bank_d[back_idx].hpos   = wr_hpos_i;
            bank_d[back_idx].planes = wr_planes_i;
        end
        if (swap_i) begin
            bank_d[bank_sel_i].valid = 1'b0;
        end
        if (clr_all_i) begin
            bank_d[back_idx].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
        end
    end

    assign front    = bank_q[bank_sel_i];
    assign dx       = {1'b0, x_i} - {1'b0, front.hpos};
    assign in_range = ~dx[8] && (dx[7:3] == 5'd0);
    assign bit_idx  = ~dx[2:0];
    assign pix_o    = {front.planes[3][bit_idx], front.planes[2][bit_idx],
                       front.planes[1][bit_idx], front.planes[0][bit_idx]};
    assign opq_o    = front.valid && in_range && active_i && (pix_o != 4'd0);

endmodule

// File: rtl/vdp_sprite_line_buffer.sv
// Double-buffered sprite line store feeding the mixer with colour, opacity and sticky status flags.
module vdp_sprite_line_buffer
    import vdp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_L,
    input  logic [8:0]      row,
    input  logic [9:0]      col,
    input  logic            wr_en,
    input  logic [2:0]      wr_slot,
    input  logic [7:0]      wr_hpos,
    input  logic [3:0][7:0] wr_planes,
    input  logic            ovf_req,
    input  logic            status_rd,
    output logic [3:0]      spr_color,
    output logic            spr_opaque,
    output logic            spr_collision,
    output logic            spr_overflow
);

    logic                 bank_sel_q, bank_sel_d;
    logic                 swap, active, in_rows, clr_all;
    logic [7:0]           x;
    logic [NUM_SLOTS-1:0] opq;
    logic [3:0]           pix [NUM_SLOTS];
    logic [3:0]           color_d;
    logic                 opaque_d, multi_opq;
    logic                 collision_d, overflow_d;

    assign swap    = (col == 10'(H_TOTAL - 1));
    assign active  = (col >= 10'(ACTIVE_START)) && (col < 10'(ACTIVE_END));
    assign x       = 8'((col - 10'(ACTIVE_START)) >> 1);
    // Swapping into a non-displayed line also empties the incoming front bank.
    assign in_rows = (row >= 9'(ROW_FIRST)) && (row <= 9'(ROW_LAST));
    assign clr_all = swap && !in_rows;
    assign bank_sel_d = swap ? ~bank_sel_q : bank_sel_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        vdp_sprite_slot u_slot (
            .clk         (clk),
            .rst_L       (rst_L),
            .bank_sel_i  (bank_sel_q),
            .swap_i      (swap),
            .clr_all_i   (clr_all),
            .wr_i        (wr_en && (wr_slot == 3'(g))),
            .wr_hpos_i   (wr_hpos),
            .wr_planes_i (wr_planes),
            .x_i         (x),
            .active_i    (active),
            .opq_o       (opq[g]),
            .pix_o       (pix[g])
        );
    end

    // Lowest opaque slot wins; a second opaque slot flags a collision.
    always_comb begin
        color_d   = 4'd0;
        opaque_d  = 1'b0;
        multi_opq = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (opq[i]) begin
                if (opaque_d) begin
                    multi_opq = 1'b1;
                end else begin
                    color_d  = pix[i];
                    opaque_d = 1'b1;
                end
            end
        end
    end

    assign collision_d = multi_opq || (spr_collision && !status_rd);
    assign overflow_d  = ovf_req   || (spr_overflow  && !status_rd);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            bank_sel_q    <= 1'b0;
            spr_color     <= 4'd0;
            spr_opaque    <= 1'b0;
            spr_collision <= 1'b0;
            spr_overflow  <= 1'b0;
        end else begin
            bank_sel_q    <= bank_sel_d;
            spr_color     <= color_d;
            spr_opaque    <= opaque_d;
            spr_collision <= collision_d;
            spr_overflow  <= overflow_d;
        end
    end

endmodule
